// File: rtl/gauss_pkg.sv
// Shared constants, types and helpers for the Gaussian stream framer and its output FIFO.
package gauss_pkg;

   localparam int FRAME_W_DEF = 400;
   localparam int FRAME_H_DEF = 300;
   localparam int BORDER      = 2;
   localparam int PIX_W       = 8;

   typedef enum logic {
      WARMUP = 1'b0,
      TRACK  = 1'b1
   } framer_state_t;

   // Filter latency for a given line width: two full lines plus the two-pixel centre offset.
   function automatic int default_lat(input int frame_w);
      return 2 * frame_w + BORDER;
   endfunction

   function automatic int coord_w(input int extent);
      return $clog2(extent);
   endfunction

   // FIFO entry layout is {eol, sof, y, x, pix}.
   function automatic int entry_width(input int x_w, input int y_w);
      return 2 + y_w + x_w + PIX_W;
   endfunction

endpackage

// File: rtl/gauss_pix_fifo.sv
// Small synchronous FIFO with a combinational head read; storage is not reset, pointers are.
module gauss_pix_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts a concurrent push.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   // Zero the head while empty so the outputs read back as 0 out of reset.
   assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/gauss_stream_framer.sv
// Framer for the 5x5 Gaussian output stream: latency compensation, border strip, FIFO output.
// Optional build macro GAUSS_DECIMATE_EN keeps only even (x, y) pixels at half-resolution coordinates.
module gauss_stream_framer
   import gauss_pkg::*;
#(
   parameter int FRAME_W    = FRAME_W_DEF,
   parameter int FRAME_H    = FRAME_H_DEF,
   parameter int LAT        = default_lat(FRAME_W),
   parameter int FIFO_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clk_en,
   input  logic [7:0]                 pix_in,
   input  logic                       resync,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [7:0]                 m_pix,
   output logic [$clog2(FRAME_W)-1:0] m_x,
   output logic [$clog2(FRAME_H)-1:0] m_y,
   output logic                       m_sof,
   output logic                       m_eol,
   output logic                       overflow
);

   localparam int X_W   = coord_w(FRAME_W);
   localparam int Y_W   = coord_w(FRAME_H);
   localparam int CNT_W = $clog2(LAT + 1);
   localparam int E_W   = entry_width(X_W, Y_W);

   localparam logic [X_W-1:0]   CX_LAST  = X_W'(FRAME_W - 1);
   localparam logic [Y_W-1:0]   CY_LAST  = Y_W'(FRAME_H - 1);
   localparam logic [X_W-1:0]   CX_LO    = X_W'(BORDER);
   localparam logic [X_W-1:0]   CX_HI    = X_W'(FRAME_W - 1 - BORDER);
   localparam logic [Y_W-1:0]   CY_LO    = Y_W'(BORDER);
   localparam logic [Y_W-1:0]   CY_HI    = Y_W'(FRAME_H - 1 - BORDER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);
`ifdef GAUSS_DECIMATE_EN
   localparam logic [X_W-1:0]   X_EOL    = X_W'((FRAME_W - 1 - 2 * BORDER) / 2);
`else
   localparam logic [X_W-1:0]   X_EOL    = X_W'(FRAME_W - 1 - 2 * BORDER);
`endif

   framer_state_t    state;
   logic [CNT_W-1:0] warm_cnt;
   logic [X_W-1:0]   cx;
   logic [Y_W-1:0]   cy;

   logic             strobe;
   logic             interior;
   logic             keep;
   logic             push_req;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [X_W-1:0]   ox;
   logic [Y_W-1:0]   oy;
   logic             o_sof;
   logic             o_eol;
   logic [E_W-1:0]   wdata;
   logic [E_W-1:0]   rdata;

   assign strobe   = clk_en && !resync;
   assign interior = (state == TRACK) &&
                     (cx >= CX_LO) && (cx <= CX_HI) &&
                     (cy >= CY_LO) && (cy <= CY_HI);

`ifdef GAUSS_DECIMATE_EN
   // BORDER is even, so the parity of cx/cy equals the parity of the output coordinate.
   assign keep = !cx[0] && !cy[0];
   assign ox   = (cx - CX_LO) >> 1;
   assign oy   = (cy - CY_LO) >> 1;
`else
   assign keep = 1'b1;
   assign ox   = cx - CX_LO;
   assign oy   = cy - CY_LO;
`endif

   assign o_sof    = (ox == '0) && (oy == '0);
   assign o_eol    = (ox == X_EOL);
   assign push_req = strobe && interior && keep;
   assign pop      = m_valid && m_ready;
   assign wdata    = {o_eol, o_sof, oy, ox, pix_in};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= WARMUP;
         warm_cnt <= '0;
         cx       <= '0;
         cy       <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_req && fifo_full && !pop) overflow <= 1'b1;
         if (clk_en) begin
            if (resync) begin
               // The resync strobe itself is the first strobe of the new warmup window.
               state    <= WARMUP;
               warm_cnt <= CNT_W'(1);
            end else if (state == WARMUP) begin
               if (warm_cnt == CNT_LAST) begin
                  // This strobe carries centre (0,0); the next one is (1,0).
                  state <= TRACK;
                  cx    <= X_W'(1);
                  cy    <= '0;
               end else begin
                  warm_cnt <= warm_cnt + 1'b1;
               end
            end else begin
               if (cx == CX_LAST) begin
                  cx <= '0;
                  cy <= (cy == CY_LAST) ? '0 : cy + 1'b1;
               end else begin
                  cx <= cx + 1'b1;
               end
            end
         end
      end
   end

   gauss_pix_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (E_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .wdata (wdata),
      .pop   (pop),
      .rdata (rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign m_valid = !fifo_empty;
   assign {m_eol, m_sof, m_y, m_x, m_pix} = rdata;

endmodule

// File: tb/tb_gauss_stream_framer.sv
// Scoreboard bench for gauss_stream_framer on a reduced frame; honours GAUSS_DECIMATE_EN.
module tb_gauss_stream_framer;

   localparam int W   = 16;
   localparam int H   = 12;
   localparam int LAT = 2 * W + 2;
   localparam int D   = 4;
   localparam int XW  = $clog2(W);
   localparam int YW  = $clog2(H);
   localparam int NX  = W - 4;
   localparam int NY  = H - 4;
`ifdef GAUSS_DECIMATE_EN
   localparam bit DEC = 1'b1;
`else
   localparam bit DEC = 1'b0;
`endif
   localparam int EXP_FRAME = DEC ? ((NX + 1) / 2) * ((NY + 1) / 2) : NX * NY;
   localparam int EXP_EOLS  = DEC ? (NY + 1) / 2 : NY;
   localparam int EOL_X     = DEC ? (NX - 1) / 2 : NX - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          clk_en;
   logic [7:0]    pix_in;
   logic          resync;
   logic          m_valid;
   logic          m_ready;
   logic [7:0]    m_pix;
   logic [XW-1:0] m_x;
   logic [YW-1:0] m_y;
   logic          m_sof;
   logic          m_eol;
   logic          overflow;

   typedef struct {
      logic [7:0] pix;
      int         x;
      int         y;
      bit         sof;
      bit         eol;
   } ent_t;

   ent_t q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   k           = 0;
   int   pcnt        = 0;
   int   pops        = 0;
   int   eols        = 0;
   bit   ovf_m       = 1'b0;

   gauss_stream_framer #(
      .FRAME_W    (W),
      .FRAME_H    (H),
      .LAT        (LAT),
      .FIFO_DEPTH (D)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clk_en   (clk_en),
      .pix_in   (pix_in),
      .resync   (resync),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_pix    (m_pix),
      .m_x      (m_x),
      .m_y      (m_y),
      .m_sof    (m_sof),
      .m_eol    (m_eol),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs against the scoreboard, drive inputs, update the reference model.
   task automatic step(input bit en, input bit rs, input bit rdy);
      ent_t e;
      int   idx, p, cx, cy, x, y;
      bit   push;
      @(negedge clk);
      chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         e = q[0];
         chk("m_pix", 32'(m_pix), 32'(e.pix));
         chk("m_x",   32'(m_x),   32'(e.x));
         chk("m_y",   32'(m_y),   32'(e.y));
         chk("m_sof", 32'(m_sof), 32'(e.sof));
         chk("m_eol", 32'(m_eol), 32'(e.eol));
      end
      chk("overflow", 32'(overflow), 32'(ovf_m));
      clk_en  = en;
      resync  = rs;
      m_ready = rdy;
      pix_in  = 8'(pcnt);
      if (q.size() > 0 && rdy) begin
         void'(q.pop_front());
         pops++;
         if (e.eol) eols++;
      end
      if (en) begin
         pcnt++;
         idx = rs ? 0 : k;
         k   = idx + 1;
         if (!rs && idx >= LAT - 1) begin
            p    = idx - (LAT - 1);
            cx   = p % W;
            cy   = (p / W) % H;
            x    = cx - 2;
            y    = cy - 2;
            push = (cx >= 2) && (cx <= W - 3) && (cy >= 2) && (cy <= H - 3);
            if (DEC) push = push && (x % 2 == 0) && (y % 2 == 0);
            if (push) begin
               if (DEC) begin
                  x = x / 2;
                  y = y / 2;
               end
               e.pix = pix_in;
               e.x   = x;
               e.y   = y;
               e.sof = (x == 0) && (y == 0);
               e.eol = (x == EOL_X);
               if (q.size() < D) q.push_back(e);
               else ovf_m = 1'b1;
            end
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b0;
      clk_en  = 1'b0;
      resync  = 1'b0;
      m_ready = 1'b0;
      pix_in  = 8'h00;
      q.delete();
      k     = 0;
      ovf_m = 1'b0;
      #1;
      chk("rst_m_valid",  32'(m_valid),  32'd0);
      chk("rst_m_pix",    32'(m_pix),    32'd0);
      chk("rst_m_x",      32'(m_x),      32'd0);
      chk("rst_m_y",      32'(m_y),      32'd0);
      chk("rst_m_sof",    32'(m_sof),    32'd0);
      chk("rst_m_eol",    32'(m_eol),    32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Strobe until the next strobe would carry centre pixel (tx, ty).
   task automatic run_to(input int tx, input int ty, input bit rdy);
      bit hit = 1'b0;
      int p;
      for (int i = 0; i < 4 * W * H + 2 * LAT; i++) begin
         p = k - (LAT - 1);
         if (k >= LAT - 1 && (p % W) == tx && ((p / W) % H) == ty) begin
            hit = 1'b1;
            break;
         end
         step(1'b1, 1'b0, rdy);
      end
      chk("run_to_reached", 32'(hit), 32'd1);
   endtask

   initial begin
      rst     = 1'b0;
      clk_en  = 1'b0;
      resync  = 1'b0;
      m_ready = 1'b0;
      pix_in  = 8'h00;
      do_reset();

      // Warmup: fewer than LAT strobes must produce nothing.
      for (int i = 0; i < LAT - 1; i++) step(1'b1, 1'b0, 1'b1);
      chk("warmup_silent", 32'(pops), 32'd0);

      // Rest of a full frame (W*H + LAT strobes in total), then drain.
      for (int i = 0; i < W * H + 1; i++) step(1'b1, 1'b0, 1'b1);
      repeat (D + 2) step(1'b0, 1'b0, 1'b1);
      chk("frame_count", 32'(pops), 32'(EXP_FRAME));
      chk("frame_eols",  32'(eols), 32'(EXP_EOLS));

      // Downstream stall for 10 interior strobes: FIFO fills, overflow latches, drain in order.
      run_to(2, 2, 1'b1);
      repeat (10) step(1'b1, 1'b0, 1'b0);
      repeat (D + 2) step(1'b0, 1'b0, 1'b1);
      chk("overflow_latched", 32'(overflow), 32'd1);

      // Strobe gaps and random backpressure.
      for (int i = 0; i < 300; i++)
         step(1'(($urandom_range(0, 3)) != 0), 1'b0, 1'(($urandom_range(0, 3)) != 0));
      repeat (D + 2) step(1'b0, 1'b0, 1'b1);

      // Full FIFO with simultaneous push and pop must not overflow.
      do_reset();
      run_to(2, 2, 1'b1);
      repeat (DEC ? 8 : 4) step(1'b1, 1'b0, 1'b0);
      repeat (6) step(1'b1, 1'b0, 1'b1);
      chk("pushpop_no_overflow", 32'(overflow), 32'd0);
      repeat (D + 2) step(1'b0, 1'b0, 1'b1);

      // Mid-frame resync: resync without a strobe is ignored, with a strobe it restarts warmup.
      run_to(5, 5, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      pops = 0;
      for (int i = 0; i < LAT - 1; i++) step(1'b1, 1'b0, 1'b1);
      chk("resync_silent", 32'(pops), 32'd0);
      for (int i = 0; i < 3 * W + 4; i++) step(1'b1, 1'b0, 1'b1);
      repeat (D + 2) step(1'b0, 1'b0, 1'b1);
      chk("resync_resumes", 32'(pops > 0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
